// File: rtl/gppcu_instr_dispatch_pkg.sv
// Shared definitions for the GPPCU instruction dispatcher: default widths,
// dispatcher FSM encoding and a saturating-increment helper.
package gppcu_instr_dispatch_pkg;

  localparam int GPPCU_DBW  = 32;  // instruction width
  localparam int GPPCU_IABW = 10;  // instruction RAM address width

  typedef enum logic [1:0] {
    DISP_IDLE  = 2'b00,
    DISP_RUN   = 2'b01,
    DISP_DRAIN = 2'b10
  } dispState_e;

  // Saturating +1 for 32-bit event counters
  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/gppcu_sync_fifo.sv
// Small synchronous FIFO (DW x DEPTH, DEPTH a power of two >= 2) with flush
// and occupancy output. A push on a full FIFO is accepted only together with
// a pop; flush has priority over push and pop.
module gppcu_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   iACLK,
  input  logic                   inRST,
  input  logic                   iPUSH,
  input  logic                   iPOP,
  input  logic                   iFLUSH,
  input  logic [DW-1:0]          iWDATA,
  output logic [DW-1:0]          oRDATA,
  output logic [$clog2(DEPTH):0] oOCC,
  output logic                   oEMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wrPtr_r;
  logic [AW-1:0] rdPtr_r;
  logic [AW:0]   occ_r;
  logic          doPush_s;
  logic          doPop_s;

  // Qualify push/pop against current occupancy
  always_comb begin
    doPop_s  = iPOP & (occ_r != {(AW+1){1'b0}});
    doPush_s = iPUSH & ((occ_r != FULL_OCC) | doPop_s);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      occ_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (iFLUSH) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      occ_r   <= '0;
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= iWDATA;
        wrPtr_r        <= wrPtr_r + AW'(1);
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + AW'(1);
      end
      case ({doPush_s, doPop_s})
        2'b10:   occ_r <= occ_r + (AW+1)'(1);
        2'b01:   occ_r <= occ_r - (AW+1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign oRDATA = mem_r[rdPtr_r];
  assign oOCC   = occ_r;
  assign oEMPTY = (occ_r == {(AW+1){1'b0}});

endmodule

// File: rtl/gppcu_instr_dispatch.sv
// GPPCU instruction dispatcher: fetches a contiguous kernel from the
// synchronous instruction RAM (1-cycle read latency) into a prefetch FIFO and
// issues it over a valid/ready handshake, pulsing oDONE after the last beat.
// Reads are credit-limited (occupancy + in-flight < FIFO_DEPTH) so the FIFO
// never overflows.
// Optional: define GPPCU_DISPATCH_PERFCNT_EN to add the oSTALL_CYCLES counter.
module gppcu_instr_dispatch
  import gppcu_instr_dispatch_pkg::*;
#(
  parameter int DBW        = GPPCU_DBW,
  parameter int IABW       = GPPCU_IABW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            iACLK,
  input  logic            inRST,
  input  logic            iSTART,
  input  logic [IABW-1:0] iSTART_ADDR,
  input  logic [IABW:0]   iINSTR_COUNT,
  input  logic            iABORT,
  output logic            oBUSY,
  output logic            oDONE,
  output logic [IABW-1:0] oIMEM_ADDR,
  output logic            oIMEM_RD,
  input  logic [DBW-1:0]  iIMEM_RDATA,
  output logic [DBW-1:0]  oINSTR,
  output logic            oINSTR_VALID,
  input  logic            iINSTR_READY
`ifdef GPPCU_DISPATCH_PERFCNT_EN
  ,output logic [31:0]    oSTALL_CYCLES
`endif
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OW:0]   DEPTH_CREDIT = (OW+1)'(FIFO_DEPTH);
  localparam logic [IABW:0] ONE_CNT      = (IABW+1)'(1);

  dispState_e      state_r;
  dispState_e      stateNext_s;
  logic [IABW-1:0] pc_r;
  logic [IABW:0]   fetchLeft_r;
  logic [IABW:0]   issueLeft_r;
  logic            inflight_r;
  logic            done_r;
  logic            startOk_s;
  logic            rd_s;
  logic            beat_s;
  logic            lastBeat_s;
  logic            push_s;
  logic [OW:0]     credit_s;
  logic [OW-1:0]   occ_s;
  logic            empty_s;

  gppcu_sync_fifo #(
    .DW    (DBW),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .iACLK  (iACLK),
    .inRST  (inRST),
    .iPUSH  (push_s),
    .iPOP   (beat_s),
    .iFLUSH (iABORT),
    .iWDATA (iIMEM_RDATA),
    .oRDATA (oINSTR),
    .oOCC   (occ_s),
    .oEMPTY (empty_s)
  );

  // Start qualification, handshake, credit check and read strobe
  always_comb begin
    startOk_s  = (state_r == DISP_IDLE) & iSTART & ~iABORT;
    beat_s     = ~empty_s & iINSTR_READY;
    credit_s   = {1'b0, occ_s} + {{OW{1'b0}}, inflight_r};
    rd_s       = (state_r == DISP_RUN) & (fetchLeft_r != {(IABW+1){1'b0}})
                 & (credit_s < DEPTH_CREDIT);
    lastBeat_s = (state_r == DISP_DRAIN) & beat_s & (issueLeft_r == ONE_CNT);
    push_s     = inflight_r & ~iABORT;
  end

  // Next-state decode; abort overrides every transition
  always_comb begin
    stateNext_s = state_r;
    if (iABORT) begin
      stateNext_s = DISP_IDLE;
    end else begin
      case (state_r)
        DISP_IDLE: begin
          if (startOk_s && (iINSTR_COUNT != {(IABW+1){1'b0}})) stateNext_s = DISP_RUN;
          else stateNext_s = DISP_IDLE;
        end
        DISP_RUN: begin
          if (rd_s && (fetchLeft_r == ONE_CNT)) stateNext_s = DISP_DRAIN;
          else stateNext_s = DISP_RUN;
        end
        DISP_DRAIN: begin
          if (lastBeat_s) stateNext_s = DISP_IDLE;
          else stateNext_s = DISP_DRAIN;
        end
        default: stateNext_s = DISP_IDLE;
      endcase
    end
  end

  // State, program counter, fetch/issue counters, in-flight flag, done pulse
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      state_r     <= DISP_IDLE;
      pc_r        <= '0;
      fetchLeft_r <= '0;
      issueLeft_r <= '0;
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      inflight_r <= rd_s & ~iABORT;
      done_r     <= ~iABORT & ((startOk_s & (iINSTR_COUNT == {(IABW+1){1'b0}})) | lastBeat_s);
      if (startOk_s) begin
        pc_r        <= iSTART_ADDR;
        fetchLeft_r <= iINSTR_COUNT;
        issueLeft_r <= iINSTR_COUNT;
      end else if (iABORT) begin
        fetchLeft_r <= '0;
        issueLeft_r <= '0;
      end else begin
        if (rd_s) begin
          pc_r        <= pc_r + IABW'(1);
          fetchLeft_r <= fetchLeft_r - ONE_CNT;
        end
        if (beat_s && (issueLeft_r != {(IABW+1){1'b0}})) begin
          issueLeft_r <= issueLeft_r - ONE_CNT;
        end
      end
    end
  end

`ifdef GPPCU_DISPATCH_PERFCNT_EN
  logic [31:0] stall_r;

  // Count cycles the core holds off a valid instruction during a kernel
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      stall_r <= 32'd0;
    end else if (startOk_s) begin
      stall_r <= 32'd0;
    end else if ((state_r != DISP_IDLE) && !empty_s && !iINSTR_READY) begin
      stall_r <= satInc32(stall_r);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign oSTALL_CYCLES = stall_r;
`endif

  assign oBUSY        = (state_r != DISP_IDLE);
  assign oDONE        = done_r;
  assign oIMEM_ADDR   = pc_r;
  assign oIMEM_RD     = rd_s;
  assign oINSTR_VALID = ~empty_s;

endmodule
